// File: rtl/approx_err_monitor_pkg.sv
// ---------------------------------------------------------------------------
// approx_mon_pkg
// Shared types and constants for the approximate-adder error monitor.
//   mon_state_e  : monitor FSM states
//   DRAIN_CYCLES : cycles spent letting the pipeline empty before reporting
//   mon_log2     : width helper used to size counters from WINDOW
//   mon_rpt_t    : one report record, sized for the largest supported
//                  configuration (WINDOW up to 65536, RES_W up to 16)
// Optional feature macro: APPROX_MON_SQERR_EN adds the squared-error sum.
// ---------------------------------------------------------------------------
package approx_mon_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_DRAIN  = 2'd2,
      ST_REPORT = 2'd3
   } mon_state_e;

   localparam int DRAIN_CYCLES = 2;

   localparam int MAX_LOG_W = 16;
   localparam int MAX_RES_W = 16;

   function automatic int mon_log2(input int value);
      return $clog2(value);
   endfunction

   typedef struct packed {
      logic [MAX_LOG_W:0]           err_cnt;
      logic [MAX_RES_W+MAX_LOG_W-1:0] sae;
      logic [MAX_RES_W-1:0]         max_err;
      logic [MAX_RES_W-1:0]         mean;
`ifdef APPROX_MON_SQERR_EN
      logic [2*MAX_RES_W+MAX_LOG_W-1:0] sse;
`endif
   } mon_rpt_t;

endpackage

// File: rtl/approx_err_monitor_if.sv
// ---------------------------------------------------------------------------
// approx_err_monitor_if
// Beat stream and report handshake of the error monitor.
//   in_valid/in_ready   : beat handshake
//   opnd                : {cin, b, a}
//   appr                : approximate adder result
//   rpt_valid/rpt_ready : report handshake
//   rpt_err_cnt, rpt_sae, rpt_max, rpt_mean : report fields
//   rpt_sse             : sum of squared errors (APPROX_MON_SQERR_EN only)
// master = beat producer / report consumer, slave = the monitor.
// ---------------------------------------------------------------------------
interface approx_err_monitor_if
   import approx_mon_pkg::*;
#(
   parameter int WINDOW = 1024,
   parameter int A_W    = 5,
   parameter int RES_W  = 7
) ();

   localparam int LOG_W = mon_log2(WINDOW);

   logic                   in_valid;
   logic                   in_ready;
   logic [2*A_W:0]         opnd;
   logic [RES_W-1:0]       appr;
   logic                   rpt_valid;
   logic                   rpt_ready;
   logic [LOG_W:0]         rpt_err_cnt;
   logic [RES_W+LOG_W-1:0] rpt_sae;
   logic [RES_W-1:0]       rpt_max;
   logic [RES_W-1:0]       rpt_mean;
`ifdef APPROX_MON_SQERR_EN
   logic [2*RES_W+LOG_W-1:0] rpt_sse;
`endif

   modport master (
      output in_valid, opnd, appr, rpt_ready,
      input  in_ready, rpt_valid, rpt_err_cnt, rpt_sae, rpt_max, rpt_mean
`ifdef APPROX_MON_SQERR_EN
      , input rpt_sse
`endif
   );

   modport slave (
      input  in_valid, opnd, appr, rpt_ready,
      output in_ready, rpt_valid, rpt_err_cnt, rpt_sae, rpt_max, rpt_mean
`ifdef APPROX_MON_SQERR_EN
      , output rpt_sse
`endif
   );

endinterface

// File: rtl/approx_err_monitor_exact_ref.sv
// ---------------------------------------------------------------------------
// approx_exact_ref
// Purely combinational exact reference for an A_W-bit two-operand adder
// with carry-in, plus the absolute error of an approximate result.
//   i_opnd  : {cin, b[A_W-1:0], a[A_W-1:0]}
//   i_appr  : approximate result, RES_W bits
//   o_exact : a + b + cin, zero-extended to RES_W
//   o_err   : |i_appr - o_exact|
// ---------------------------------------------------------------------------
module approx_exact_ref
   import approx_mon_pkg::*;
#(
   parameter int A_W   = 5,
   parameter int RES_W = 7
) (
   input  logic [2*A_W:0]   i_opnd,
   input  logic [RES_W-1:0] i_appr,
   output logic [RES_W-1:0] o_exact,
   output logic [RES_W-1:0] o_err
);

   logic [A_W:0]   w_sum;
   logic [RES_W:0] w_diff;

   // The sum is formed one bit wider than the operands so the carry-out is
   // kept; the difference gets one extra bit so its sign is visible and the
   // magnitude can be recovered by negation.
   always_comb begin
      w_sum   = {1'b0, i_opnd[A_W-1:0]} + {1'b0, i_opnd[2*A_W-1:A_W]}
              + (A_W+1)'(i_opnd[2*A_W]);
      o_exact = RES_W'(w_sum);
      w_diff  = {1'b0, i_appr} - {1'b0, o_exact};
      o_err   = w_diff[RES_W] ? RES_W'(-w_diff) : w_diff[RES_W-1:0];
   end

endmodule

// File: rtl/approx_err_monitor.sv
// ---------------------------------------------------------------------------
// approx_err_monitor
// Measures the error of an approximate adder over windows of WINDOW beats
// and publishes count / sum / max / mean of the absolute error per window.
//   clk, rst_n : rising-edge clock, asynchronous active-low reset
//   start      : IDLE -> RUN pulse
//   abort      : synchronous return to IDLE, clears everything
//   cont       : at report handshake, 1 = start next window, 0 = IDLE
//   busy       : monitor not idle
//   bus        : beat stream and report handshake (slave side)
// Pipeline: beat accepted at T, error registered at T+1, accumulators at T+2.
// Optional macro APPROX_MON_SQERR_EN adds rpt_sse (sum of squared errors).
// ---------------------------------------------------------------------------
module approx_err_monitor
   import approx_mon_pkg::*;
#(
   parameter int WINDOW = 1024,
   parameter int A_W    = 5,
   parameter int RES_W  = 7
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic abort,
   input  logic cont,
   output logic busy,
   approx_err_monitor_if.slave bus
);

   localparam int LOG_W = mon_log2(WINDOW);
   localparam int CNT_W = LOG_W + 1;
   localparam int SAE_W = RES_W + LOG_W;
`ifdef APPROX_MON_SQERR_EN
   localparam int SSE_W = 2*RES_W + LOG_W;
`endif

   mon_state_e         r_state;
   mon_state_e         w_stateNxt;
   logic               w_accept;
   logic               w_loadRpt;
   logic               w_clearAcc;
   logic [LOG_W-1:0]   r_sampleCnt;
   logic [1:0]         r_drainCnt;
   logic [RES_W-1:0]   w_exact;
   logic [RES_W-1:0]   w_err;
   logic               r_s1Valid;
   logic               r_s1Nz;
   logic [RES_W-1:0]   r_s1Err;
   logic [CNT_W-1:0]   r_errCnt;
   logic [SAE_W-1:0]   r_sae;
   logic [RES_W-1:0]   r_max;
   logic [CNT_W-1:0]   r_rptErrCnt;
   logic [SAE_W-1:0]   r_rptSae;
   logic [RES_W-1:0]   r_rptMax;
`ifdef APPROX_MON_SQERR_EN
   logic [2*RES_W-1:0] r_s1Sq;
   logic [SSE_W-1:0]   r_sse;
   logic [SSE_W-1:0]   r_rptSse;
`endif

   approx_exact_ref #(.A_W(A_W), .RES_W(RES_W)) u_exactRef (
      .i_opnd  (bus.opnd),
      .i_appr  (bus.appr),
      .o_exact (w_exact),
      .o_err   (w_err)
   );

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= ST_IDLE;
      else        r_state <= w_stateNxt;
   end

   // Next-state and per-cycle strobes. Abort is applied last so it wins over
   // a start, an acceptance or a report handshake in the same cycle.
   always_comb begin
      w_stateNxt = r_state;
      w_accept   = 1'b0;
      w_loadRpt  = 1'b0;
      w_clearAcc = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_stateNxt = ST_RUN;
               w_clearAcc = 1'b1;
            end
         end
         ST_RUN: begin
            w_accept = bus.in_valid;
            if (bus.in_valid && (r_sampleCnt == LOG_W'(WINDOW-1)))
               w_stateNxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (r_drainCnt == 2'(DRAIN_CYCLES-1)) begin
               w_stateNxt = ST_REPORT;
               w_loadRpt  = 1'b1;
            end
         end
         ST_REPORT: begin
            if (bus.rpt_ready) begin
               w_stateNxt = cont ? ST_RUN : ST_IDLE;
               w_clearAcc = 1'b1;
            end
         end
         default: w_stateNxt = ST_IDLE;
      endcase
      if (abort) begin
         w_stateNxt = ST_IDLE;
         w_accept   = 1'b0;
         w_loadRpt  = 1'b0;
         w_clearAcc = 1'b1;
      end
   end

   // Sample counter wraps to zero on the last beat because WINDOW is a power
   // of two; the drain counter only runs while in DRAIN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sampleCnt <= '0;
         r_drainCnt  <= '0;
      end else begin
         if (w_clearAcc)    r_sampleCnt <= '0;
         else if (w_accept) r_sampleCnt <= r_sampleCnt + LOG_W'(1);
         if (r_state == ST_DRAIN && !abort) r_drainCnt <= r_drainCnt + 2'd1;
         else                               r_drainCnt <= '0;
      end
   end

   // First pipeline stage: capture the error of an accepted beat. The
   // nonzero flag uses the exact sum directly rather than testing the error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1Valid <= 1'b0;
         r_s1Nz    <= 1'b0;
         r_s1Err   <= '0;
`ifdef APPROX_MON_SQERR_EN
         r_s1Sq    <= '0;
`endif
      end else begin
         r_s1Valid <= w_accept;
         if (w_accept) begin
            r_s1Nz  <= (bus.appr != w_exact);
            r_s1Err <= w_err;
`ifdef APPROX_MON_SQERR_EN
            r_s1Sq  <= (2*RES_W)'(w_err) * (2*RES_W)'(w_err);
`endif
         end
      end
   end

   // Second stage: window accumulators. Widths are chosen so the sums can
   // hold WINDOW worst-case errors without overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_errCnt <= '0;
         r_sae    <= '0;
         r_max    <= '0;
`ifdef APPROX_MON_SQERR_EN
         r_sse    <= '0;
`endif
      end else if (w_clearAcc) begin
         r_errCnt <= '0;
         r_sae    <= '0;
         r_max    <= '0;
`ifdef APPROX_MON_SQERR_EN
         r_sse    <= '0;
`endif
      end else if (r_s1Valid) begin
         if (r_s1Nz) r_errCnt <= r_errCnt + CNT_W'(1);
         r_sae <= r_sae + SAE_W'(r_s1Err);
         if (r_s1Err > r_max) r_max <= r_s1Err;
`ifdef APPROX_MON_SQERR_EN
         r_sse <= r_sse + SSE_W'(r_s1Sq);
`endif
      end
   end

   // Report registers snapshot the accumulators once per window and then
   // hold for as long as the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rptErrCnt <= '0;
         r_rptSae    <= '0;
         r_rptMax    <= '0;
`ifdef APPROX_MON_SQERR_EN
         r_rptSse    <= '0;
`endif
      end else if (abort) begin
         r_rptErrCnt <= '0;
         r_rptSae    <= '0;
         r_rptMax    <= '0;
`ifdef APPROX_MON_SQERR_EN
         r_rptSse    <= '0;
`endif
      end else if (w_loadRpt) begin
         r_rptErrCnt <= r_errCnt;
         r_rptSae    <= r_sae;
         r_rptMax    <= r_max;
`ifdef APPROX_MON_SQERR_EN
         r_rptSse    <= r_sse;
`endif
      end
   end

   // Handshake outputs follow the state directly; the mean is the top
   // RES_W bits of the error sum, i.e. the sum divided by WINDOW.
   assign bus.in_ready    = (r_state == ST_RUN);
   assign bus.rpt_valid   = (r_state == ST_REPORT);
   assign busy            = (r_state != ST_IDLE);
   assign bus.rpt_err_cnt = r_rptErrCnt;
   assign bus.rpt_sae     = r_rptSae;
   assign bus.rpt_max     = r_rptMax;
   assign bus.rpt_mean    = r_rptSae[SAE_W-1:LOG_W];
`ifdef APPROX_MON_SQERR_EN
   assign bus.rpt_sse     = r_rptSse;
`endif

endmodule

// File: tb/tb_approx_err_monitor.sv
// ---------------------------------------------------------------------------
// tb_approx_err_monitor
// Self-checking bench for approx_err_monitor with WINDOW=4, A_W=5, RES_W=7.
// Table-driven windows with hand-computed reports, hand-written corner
// sequences (backpressure, abort during handshake, reset mid-window,
// squared-error sum) and randomized windows checked against a plain
// arithmetic model of the error statistics.
// ---------------------------------------------------------------------------
module tb_approx_err_monitor;
   import approx_mon_pkg::*;

   localparam int WINDOW = 4;
   localparam int A_W    = 5;
   localparam int RES_W  = 7;

   logic clk;
   logic rst_n;
   logic start;
   logic abort;
   logic cont;
   logic busy;

   approx_err_monitor_if #(.WINDOW(WINDOW), .A_W(A_W), .RES_W(RES_W)) bus ();

   approx_err_monitor #(.WINDOW(WINDOW), .A_W(A_W), .RES_W(RES_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .abort (abort),
      .cont  (cont),
      .busy  (busy),
      .bus   (bus)
   );

   typedef struct {
      string    name;
      int       a;
      int       b;
      int       cin;
      int       appr;
      mon_rpt_t exp;
   } vec_t;

   int       nCompared   = 0;
   int       nMismatched = 0;
   int       modelQ[$];
   vec_t     vecs[6];

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One comparison: counts it and reports a failure line when it differs.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      nCompared++;
      if (act !== exp) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int absErr(input int a, input int b, input int cin, input int appr);
      int exact;
      exact = a + b + cin;
      return (appr >= exact) ? (appr - exact) : (exact - appr);
   endfunction

   function automatic mon_rpt_t mkRpt(input int cnt, input int sae, input int mx, input int mean);
      mon_rpt_t r;
      r         = '0;
      r.err_cnt = (MAX_LOG_W+1)'(cnt);
      r.sae     = (MAX_RES_W+MAX_LOG_W)'(sae);
      r.max_err = MAX_RES_W'(mx);
      r.mean    = MAX_RES_W'(mean);
      return r;
   endfunction

   // Window statistics straight from the list of per-beat errors.
   function automatic mon_rpt_t modelReport();
      mon_rpt_t r;
      int       cnt;
      int       mx;
      longint   sae;
      longint   sse;
      cnt = 0;
      mx  = 0;
      sae = 0;
      sse = 0;
      foreach (modelQ[i]) begin
         if (modelQ[i] != 0) cnt++;
         if (modelQ[i] > mx) mx = modelQ[i];
         sae += modelQ[i];
         sse += longint'(modelQ[i]) * longint'(modelQ[i]);
      end
      r = mkRpt(cnt, int'(sae), mx, int'(sae / WINDOW));
`ifdef APPROX_MON_SQERR_EN
      r.sse = (2*MAX_RES_W+MAX_LOG_W)'(sse);
`endif
      return r;
   endfunction

   task automatic checkReport(input string tag, input mon_rpt_t e);
      checkOutput({tag, ".err_cnt"}, 64'(bus.rpt_err_cnt), 64'(e.err_cnt));
      checkOutput({tag, ".sae"},     64'(bus.rpt_sae),     64'(e.sae));
      checkOutput({tag, ".max"},     64'(bus.rpt_max),     64'(e.max_err));
      checkOutput({tag, ".mean"},    64'(bus.rpt_mean),    64'(e.mean));
`ifdef APPROX_MON_SQERR_EN
      checkOutput({tag, ".sse"},     64'(bus.rpt_sse),     64'(e.sse));
`endif
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, ".in_ready"},  64'(bus.in_ready),  64'd0);
      checkOutput({tag, ".rpt_valid"}, 64'(bus.rpt_valid), 64'd0);
      checkOutput({tag, ".busy"},      64'(busy),          64'd0);
      checkReport(tag, mkRpt(0, 0, 0, 0));
   endtask

   // Present one beat, waiting (bounded) for the monitor to be ready.
   task automatic applyStimulus(input int a, input int b, input int cin, input int appr);
      int waitCyc;
      waitCyc = 0;
      while (bus.in_ready !== 1'b1 && waitCyc < 20) begin
         tick();
         waitCyc++;
      end
      if (waitCyc >= 20) checkOutput("in_ready_wait", 64'(bus.in_ready), 64'd1);
      bus.in_valid = 1'b1;
      bus.opnd     = {cin[0], b[A_W-1:0], a[A_W-1:0]};
      bus.appr     = appr[RES_W-1:0];
      modelQ.push_back(absErr(a, b, cin, appr));
      tick();
      bus.in_valid = 1'b0;
   endtask

   task automatic startPulse();
      start = 1'b1;
      tick();
      start = 1'b0;
      checkOutput("start.in_ready", 64'(bus.in_ready), 64'd1);
   endtask

   // Called right after the final acceptance edge: the report must appear
   // exactly three cycles after that acceptance, with no beats taken.
   task automatic runTail(input string tag, input mon_rpt_t e, input bit junk);
      if (junk) begin
         bus.in_valid = 1'b1;
         bus.opnd     = (2*A_W+1)'($urandom);
         bus.appr     = RES_W'($urandom);
      end
      checkOutput({tag, ".t1.rpt_valid"}, 64'(bus.rpt_valid), 64'd0);
      checkOutput({tag, ".t1.in_ready"},  64'(bus.in_ready),  64'd0);
      tick();
      checkOutput({tag, ".t2.rpt_valid"}, 64'(bus.rpt_valid), 64'd0);
      checkOutput({tag, ".t2.in_ready"},  64'(bus.in_ready),  64'd0);
      tick();
      checkOutput({tag, ".t3.rpt_valid"}, 64'(bus.rpt_valid), 64'd1);
      checkOutput({tag, ".t3.in_ready"},  64'(bus.in_ready),  64'd0);
      checkReport(tag, e);
   endtask

   task automatic doHandshake(input bit c);
      bus.rpt_ready = 1'b1;
      cont          = c;
      tick();
      bus.rpt_ready = 1'b0;
      cont          = 1'b0;
      bus.in_valid  = 1'b0;
      if (c) checkOutput("hs.in_ready", 64'(bus.in_ready), 64'd1);
      else   checkOutput("hs.busy",     64'(busy),         64'd0);
   endtask

   task automatic setVec(input int idx, input string name, input int a, input int b,
                         input int cin, input int appr, input int cnt, input int sae,
                         input int mx, input int mean);
      vecs[idx].name = name;
      vecs[idx].a    = a;
      vecs[idx].b    = b;
      vecs[idx].cin  = cin;
      vecs[idx].appr = appr;
      vecs[idx].exp  = mkRpt(cnt, sae, mx, mean);
   endtask

   task automatic runAll();
      mon_rpt_t e;
      bit       inRun;
      int       a;
      int       b;
      int       cin;
      int       appr;
      int       gap;

      rst_n         = 1'b0;
      start         = 1'b0;
      abort         = 1'b0;
      cont          = 1'b0;
      bus.in_valid  = 1'b0;
      bus.opnd      = '0;
      bus.appr      = '0;
      bus.rpt_ready = 1'b0;
      tick();
      tick();
      checkReset("reset");
      rst_n = 1'b1;
      tick();

      // Table of constant-operand windows with hand-computed reports.
      setVec(0, "zero",    0,  0, 0,   0, 0,   0,   0,   0);
      setVec(1, "under3", 31, 31, 1,  60, 4,  12,   3,   3);
      setVec(2, "over2",  10,  5, 0,  17, 4,   8,   2,   2);
      setVec(3, "maxerr",  0,  0, 0, 127, 4, 508, 127, 127);
      setVec(4, "exact",   7,  8, 1,  16, 0,   0,   0,   0);
      setVec(5, "under7",  3,  4, 0,   0, 4,  28,   7,   7);
`ifdef APPROX_MON_SQERR_EN
      vecs[0].exp.sse = '0;
      vecs[1].exp.sse = 48'd36;
      vecs[2].exp.sse = 48'd16;
      vecs[3].exp.sse = 48'd64516;
      vecs[4].exp.sse = '0;
      vecs[5].exp.sse = 48'd196;
`endif
      for (int i = 0; i < 6; i++) begin
         modelQ.delete();
         startPulse();
         for (int k = 0; k < WINDOW; k++)
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].appr);
         runTail(vecs[i].name, vecs[i].exp, 1'b0);
         doHandshake(1'b0);
      end

      // Report backpressure, then continue straight into a fresh window.
      e = mkRpt(4, 12, 3, 3);
`ifdef APPROX_MON_SQERR_EN
      e.sse = 48'd36;
`endif
      modelQ.delete();
      startPulse();
      for (int k = 0; k < WINDOW; k++) applyStimulus(31, 31, 1, 60);
      runTail("bp", e, 1'b0);
      for (int k = 0; k < 10; k++) begin
         tick();
         checkOutput("bp.hold.rpt_valid", 64'(bus.rpt_valid), 64'd1);
         checkOutput("bp.hold.in_ready",  64'(bus.in_ready),  64'd0);
         checkReport("bp.hold", e);
      end
      doHandshake(1'b1);
      modelQ.delete();
      for (int k = 0; k < WINDOW; k++) begin
         a = $urandom_range(0, 31);
         b = $urandom_range(0, 31);
         applyStimulus(a, b, 0, $urandom_range(0, 127));
      end
      runTail("bp.next", modelReport(), 1'b0);
      doHandshake(1'b0);

      // Abort in the same cycle as the report handshake.
      modelQ.delete();
      startPulse();
      for (int k = 0; k < WINDOW; k++) applyStimulus(31, 31, 1, 60);
      runTail("ab.pre", e, 1'b0);
      bus.rpt_ready = 1'b1;
      cont          = 1'b1;
      abort         = 1'b1;
      tick();
      bus.rpt_ready = 1'b0;
      cont          = 1'b0;
      abort         = 1'b0;
      checkOutput("ab.busy",      64'(busy),          64'd0);
      checkOutput("ab.rpt_valid", 64'(bus.rpt_valid), 64'd0);
      checkOutput("ab.in_ready",  64'(bus.in_ready),  64'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         checkOutput("ab.idle.in_ready", 64'(bus.in_ready), 64'd0);
         checkOutput("ab.idle.busy",     64'(busy),         64'd0);
      end
      modelQ.delete();
      startPulse();
      for (int k = 0; k < WINDOW; k++) applyStimulus(5, 6, 1, 12);
      runTail("ab.post", mkRpt(0, 0, 0, 0), 1'b0);
      doHandshake(1'b0);

      // Reset asserted part way through a window.
      modelQ.delete();
      startPulse();
      applyStimulus(31, 31, 1, 60);
      applyStimulus(31, 31, 1, 60);
      #3;
      rst_n = 1'b0;
      #2;
      checkReset("midrst");
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("midrst.idle.busy", 64'(busy), 64'd0);
      e = mkRpt(4, 4, 1, 1);
`ifdef APPROX_MON_SQERR_EN
      e.sse = 48'd4;
`endif
      modelQ.delete();
      startPulse();
      for (int k = 0; k < WINDOW; k++) applyStimulus(2, 3, 1, 7);
      runTail("rst.post", e, 1'b0);
      doHandshake(1'b0);

      // Errors 1, 2, 3, 0 within one window.
      e = mkRpt(3, 6, 3, 1);
`ifdef APPROX_MON_SQERR_EN
      e.sse = 48'd14;
`endif
      modelQ.delete();
      startPulse();
      applyStimulus(1, 1, 0, 3);
      applyStimulus(1, 1, 0, 0);
      applyStimulus(4, 4, 1, 6);
      applyStimulus(2, 2, 0, 4);
      runTail("sq", e, 1'b0);
      doHandshake(1'b0);

      // Randomized windows: idle gaps, stray start pulses while running,
      // junk beats offered while not ready, random report stalls.
      inRun = 1'b0;
      for (int w = 0; w < 12; w++) begin
         modelQ.delete();
         if (!inRun) startPulse();
         for (int k = 0; k < WINDOW; k++) begin
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
               start = ($urandom_range(0, 3) == 0);
               tick();
               start = 1'b0;
            end
            a    = $urandom_range(0, 31);
            b    = $urandom_range(0, 31);
            cin  = $urandom_range(0, 1);
            appr = ($urandom_range(0, 3) == 0) ? (a + b + cin) : $urandom_range(0, 127);
            applyStimulus(a, b, cin, appr);
         end
         runTail($sformatf("rnd%0d", w), modelReport(), 1'b1);
         gap = $urandom_range(0, 4);
         for (int g = 0; g < gap; g++) begin
            tick();
            checkOutput("rnd.hold.rpt_valid", 64'(bus.rpt_valid), 64'd1);
            checkOutput("rnd.hold.in_ready",  64'(bus.in_ready),  64'd0);
         end
         inRun = 1'($urandom_range(0, 1));
         doHandshake(inRun);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   endtask

   initial runAll();

   // Overall time bound in case the design stops responding.
   initial begin
      #2000000;
      nMismatched++;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $fatal(1, "[TB] time limit");
   end

endmodule

// File: doc/approx_err_monitor.md
# approx_err_monitor

Streaming error-measurement stage placed directly downstream of an approximate 11-input/7-output adder. Each accepted beat carries the adder's operand vector and approximate result. The block recomputes the exact sum and accumulates error statistics over a fixed window of samples. At the end of each window it publishes a report through a valid/ready handshake, so approximate adder variants can be characterised in simulation or on FPGA without a golden model in software.

## Interface
- `WINDOW`, default 1024: samples per report; power of two, 2..65536.
- `A_W`, default 5: width of operand field a.
- `RES_W`, default 7: approximate result width; must equal `A_W+2`.
- `clk` input 1: clock; all flops are rising-edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `start` input 1: single-cycle pulse; IDLE→RUN.
- `abort` input 1: synchronous; returns to IDLE from any state and clears all state.
- `cont` input 1: sampled at report handshake; 1 = re-enter RUN, 0 = IDLE.
- `in_valid` input 1: operand/result beat valid.
- `in_ready` output 1: beat accepted when `in_valid && in_ready`.
- `opnd` input `2*A_W+1`: field a = [A_W-1:0], field b = [2A_W-1:A_W], cin = MSB.
- `appr` input `RES_W`: approximate adder output, po6..po0 packed MSB..LSB.
- `rpt_valid` output 1: report available.
- `rpt_ready` input 1: report consumed when `rpt_valid && rpt_ready`.
- `rpt_err_cnt` output `log2(WINDOW)+1`: samples with nonzero error.
- `rpt_sae` output `RES_W+log2(WINDOW)`: sum of absolute errors.
- `rpt_max` output `RES_W`: maximum absolute error.
- `rpt_mean` output `RES_W`: `rpt_sae >> log2(WINDOW)`, truncated.
- `busy` output 1: state != IDLE.

## Operation
- FSM states: IDLE, RUN, DRAIN, REPORT.
  - IDLE → RUN on `start`.
  - RUN → DRAIN when the WINDOW-th beat is accepted.
  - DRAIN → REPORT after 2 cycles.
  - REPORT → RUN (`cont`=1) or IDLE (`cont`=0) on the report handshake.
- `in_ready` = (state==RUN). It drops in the cycle after the WINDOW-th acceptance, so no beat beyond WINDOW is ever taken.
- Exact sum: a + b + cin, computed `A_W+1` bits wide and zero-extended to `RES_W`. Error = |appr − exact| as unsigned `RES_W`-bit; the subtraction is done in `RES_W+1` bits.
- Accumulators:
  - err_cnt increments when error != 0.
  - sae adds the error; it cannot overflow given the declared widths.
  - max = max(max, error).
- Report registers load once, on DRAIN→REPORT. They hold stable while `rpt_valid`=1 and `rpt_ready`=0.
- Accumulators and sample counter clear on the report handshake, on `abort`, and on `start`.
- `start` outside IDLE is ignored.
- `abort` takes priority over every other event in the same cycle, including a report handshake. Its effects: state=IDLE, `rpt_valid`=0, pipeline valids cleared.
- `in_valid` with `in_ready`=0: no effect; the data is not sampled.

## Timing
- Reset values: `in_ready`=0, `rpt_valid`=0, `busy`=0, all `rpt_*` buses 0, state IDLE.
- Pipeline: acceptance at cycle T; exact sum and abs error registered at T+1; accumulators updated at T+2.
- `rpt_valid` rises 3 cycles after the final acceptance.
- Report handshake at cycle R with `cont`=1: `in_ready`=1 at R+1.
- Throughput: 1 beat/cycle in RUN. Window overhead: 3 cycles plus report backpressure.
- `rst_n` deassertion mid-window discards all partial statistics. No report is issued for that window.

## Configuration
- `APPROX_MON_SQERR_EN` defined:
  - adds output `rpt_sse`, width `2*RES_W+log2(WINDOW)`, the sum of squared errors;
  - adds one multiplier in the T+1 stage, which keeps the same latency;
  - `rpt_sse` follows the same load, hold and clear rules as the other report registers.
- Not defined: the port and its logic are absent; all other behaviour is identical.

## Structure
- Package `approx_mon_pkg` holds:
  - the FSM state enum `mon_state_e`;
  - `DRAIN_CYCLES`=2;
  - a `clog2`-based width function;
  - the report struct `mon_rpt_t` grouping the `rpt_*` fields.
- Sub-module `approx_exact_ref`: purely combinational. Operand vector in; exact sum and absolute error against `appr` out. It is reused by other monitors in the approximate-arithmetic flow.

## Test plan
- WINDOW=4, `opnd`=0, `appr`=0 for 4 beats → err_cnt=0, sae=0, max=0, mean=0, `rpt_valid` 3 cycles after the 4th acceptance.
- WINDOW=4; a=31, b=31, cin=1 (exact 63); `appr`=60 for 4 beats → err_cnt=4, sae=12, max=3, mean=3.
- Hold `rpt_ready`=0 for 10 cycles → `rpt_*` stable and `in_ready`=0 throughout. Then accept with `cont`=1 → `in_ready`=1 on the next cycle and a fresh window counted from 0.
- `abort` in the same cycle as a report handshake → IDLE, `rpt_valid`=0, no new window. A subsequent `start` plus 4 zero-error beats → err_cnt=0.
- Assert `rst_n`=0 after 2 of 4 beats; release; `start`; 4 beats with `appr`=exact+1 → err_cnt=4, sae=4, max=1.
- With `APPROX_MON_SQERR_EN` defined: 4 beats with errors 1, 2, 3, 0 → sse=14, sae=6, err_cnt=3, max=3.
